wb_arbiter_rr: RTL and testbench

// - Round-robin Wishbone arbiter: N_MASTERS initiators share one target port (one slave slot of the NxN interconnect, or a bare slave).
// - Grant is held for the whole bus cycle (CYC), so the owner's bursts and RMW sequences are never split.
// - Fair rotation, registered grant, optional stall watchdog.

---
 rtl/wb_arbiter_rr_if.sv | 57 +++++
 rtl/wb_arbiter_rr.sv | 157 +++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_rr_if.sv
// Signal bundle around the round-robin Wishbone arbiter: N master-side request ports and one target port.
// The slave modport is the arbiter's view; the master modport is the surrounding initiators and target.
interface wb_arbiter_rr_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int N_MASTERS     = 4
);
  localparam int AW    = WB_ADDR_WIDTH;
  localparam int DW    = WB_DATA_WIDTH;
  localparam int SW    = WB_DATA_WIDTH / 8;
  localparam int MID_W = $clog2(N_MASTERS);

  // Master side, master i packed at [i*width +: width]
  logic [N_MASTERS-1:0]      m_cyc;
  logic [N_MASTERS-1:0]      m_stb;
  logic [N_MASTERS-1:0]      m_we;
  logic [N_MASTERS*AW-1:0]   m_adr;
  logic [N_MASTERS*DW-1:0]   m_dat_w;
  logic [N_MASTERS*SW-1:0]   m_sel;
  logic [N_MASTERS*3-1:0]    m_cti;
  logic [N_MASTERS*2-1:0]    m_bte;
  logic [DW-1:0]             m_dat_r;
  logic [N_MASTERS-1:0]      m_ack;
  logic [N_MASTERS-1:0]      m_err;

  // Target side
  logic                      s_cyc;
  logic                      s_stb;
  logic                      s_we;
  logic [AW-1:0]             s_adr;
  logic [DW-1:0]             s_dat_w;
  logic [SW-1:0]             s_sel;
  logic [2:0]                s_cti;
  logic [1:0]                s_bte;
  logic [DW-1:0]             s_dat_r;
  logic                      s_ack;
  logic                      s_err;

  logic [N_MASTERS-1:0]      gnt;
  logic [MID_W-1:0]          gnt_id;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, m_cti, m_bte,
    input  s_dat_r, s_ack, s_err,
    output m_dat_r, m_ack, m_err,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, s_cti, s_bte,
    output gnt, gnt_id
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, m_cti, m_bte,
    output s_dat_r, s_ack, s_err,
    input  m_dat_r, m_ack, m_err,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, s_cti, s_bte,
    input  gnt, gnt_id
  );
endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter; grant is held for the owner's whole CYC so bursts and RMW stay atomic.
// Define WB_ARB_TIMEOUT_EN to add a stall watchdog that aborts the owner's cycle with a one-cycle ERR.
module wb_arbiter_rr #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic            clk,
  input logic            rst,
  wb_arbiter_rr_if.slave bus
);
  localparam int AW    = WB_ADDR_WIDTH;
  localparam int DW    = WB_DATA_WIDTH;
  localparam int SW    = WB_DATA_WIDTH / 8;
  localparam int N     = N_MASTERS;
  localparam int MID_W = $clog2(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > 16) begin : g_bad_n_masters
    $error("wb_arbiter_rr: N_MASTERS must be 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_arbiter_rr: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY
`ifdef WB_ARB_TIMEOUT_EN
    , ST_ABORT
`endif
  } state_e;

  state_e             state_q;
  logic [N-1:0]       gnt_q;
  logic [MID_W-1:0]   gnt_id_q;
  logic [MID_W-1:0]   last_q;
  logic               owned_q;   // data fields stay zero until the first grant after reset

  // Round-robin pick: first requester after the previous winner
  logic               req_found;
  logic [MID_W-1:0]   win_id;
  logic [N-1:0]       win_oh;

  always_comb begin
    int               idx;
    logic [MID_W-1:0] cand;
    // NOTE: every variable gets a default before any conditional update, so no latches are inferred.
    req_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N) idx = idx - N;
      cand = MID_W'(idx);
      if (!req_found && bus.m_cyc[cand]) begin
        req_found    = 1'b1;
        win_id       = cand;
        win_oh[cand] = 1'b1;
      end
    end
  end

  logic busy;
  logic own_cyc;
  logic own_stb;
  logic own_we;

  assign busy    = (state_q == ST_BUSY);
  assign own_cyc = bus.m_cyc[gnt_id_q];
  assign own_stb = bus.m_stb[gnt_id_q];
  assign own_we  = bus.m_we[gnt_id_q];

  assign bus.s_cyc   = busy & own_cyc;
  assign bus.s_stb   = busy & own_cyc & own_stb;
  assign bus.s_we    = busy & own_cyc & own_we;
  assign bus.s_adr   = owned_q ? bus.m_adr[gnt_id_q*AW +: AW]   : '0;
  assign bus.s_dat_w = owned_q ? bus.m_dat_w[gnt_id_q*DW +: DW] : '0;
  assign bus.s_sel   = owned_q ? bus.m_sel[gnt_id_q*SW +: SW]   : '0;
  assign bus.s_cti   = owned_q ? bus.m_cti[gnt_id_q*3 +: 3]     : '0;
  assign bus.s_bte   = owned_q ? bus.m_bte[gnt_id_q*2 +: 2]     : '0;

  assign bus.m_dat_r = bus.s_dat_r;
  assign bus.m_ack   = busy ? (gnt_q & {N{bus.s_ack}}) : '0;
  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              abort_err_q;
  logic              stalled;

  assign stalled     = busy & bus.s_stb & ~bus.s_ack & ~bus.s_err;
  assign bus.m_err   = (busy ? (gnt_q & {N{bus.s_err}}) : '0)
                     | (abort_err_q ? gnt_q : '0);
`else
  assign bus.m_err   = busy ? (gnt_q & {N{bus.s_err}}) : '0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      last_q      <= MID_W'(N - 1);
      owned_q     <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      wdog_q      <= '0;
      abort_err_q <= 1'b0;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      wdog_q      <= stalled ? wdog_q + 1'b1 : '0;
      abort_err_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (req_found) begin
            state_q  <= ST_BUSY;
            gnt_q    <= win_oh;
            gnt_id_q <= win_id;
            last_q   <= win_id;
            owned_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (stalled && wdog_q == WDOG_LAST) begin
            state_q     <= ST_ABORT;
            abort_err_q <= 1'b1;
          end
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        // Grant is kept until the owner acknowledges the abort by dropping CYC
        ST_ABORT: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr (N=4, TIMEOUT_CYCLES=16): reset, fairness, burst lock, routing,
// mid-cycle reset and stall behaviour, with or without WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter_rr;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_rr_if #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .N_MASTERS(N)) bus ();

  wb_arbiter_rr #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .N_MASTERS     (N),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int o;
    int ack1;
    int ack0;

    bus.m_cyc   = '0;
    bus.m_stb   = '0;
    bus.m_we    = '0;
    bus.m_adr   = '0;
    bus.m_dat_w = '0;
    bus.m_sel   = '0;
    bus.m_cti   = '0;
    bus.m_bte   = '0;
    bus.s_dat_r = '0;
    bus.s_ack   = 1'b0;
    bus.s_err   = 1'b0;

    // Reset held for 3 edges with every master requesting and the target acking
    rst       = 1'b1;
    bus.m_cyc = 4'b1111;
    bus.s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      check("rst_gnt", bus.gnt, 4'b0000);
      check("rst_scyc", bus.s_cyc, 1'b0);
      check("rst_mack", bus.m_ack, 4'b0000);
    end
    check("rst_sadr", bus.s_adr, 32'h0);
    rst       = 1'b0;
    bus.s_ack = 1'b0;

    next_cycle(); #1;
    check("release_gnt", bus.gnt, 4'b0001);
    check("release_scyc", bus.s_cyc, 1'b1);

    // Fairness: all four keep requesting, each owner does one beat then drops CYC for a cycle
    for (int k = 0; k < 5; k++) begin
      o = order[k];
      check("fair_gnt", bus.gnt, 64'(1) << o);
      check("fair_gnt_id", bus.gnt_id, 64'(o));
      bus.m_stb[o] = 1'b1;
      bus.s_ack    = 1'b1;
      #1;
      check("fair_ack", bus.m_ack, 64'(1) << o);
      next_cycle();
      bus.m_cyc[o] = 1'b0;
      bus.m_stb[o] = 1'b0;
      bus.s_ack    = 1'b0;
      #1;
      check("fair_drop_scyc", bus.s_cyc, 1'b0);
      next_cycle();
      bus.m_cyc[o] = 1'b1;
      #1;
      check("fair_gap_gnt", bus.gnt, 4'b0000);
      next_cycle(); #1;
    end
    check("fair_next_owner", bus.gnt, 4'b0010);
    bus.m_cyc = '0;
    next_cycle(); #1;

    // Burst lock: m1 runs an 8-beat incrementing read while m0 requests throughout
    bus.m_cyc[1]      = 1'b1;
    bus.m_stb[1]      = 1'b1;
    bus.m_we[1]       = 1'b0;
    bus.m_cti[3 +: 3] = 3'b010;
    next_cycle(); #1;
    check("burst_gnt", bus.gnt, 4'b0010);
    check("burst_cti", bus.s_cti, 3'b010);
    bus.m_cyc[0] = 1'b1;
    ack1 = 0;
    ack0 = 0;
    for (int b = 0; b < 8; b++) begin
      bus.s_ack   = 1'b1;
      bus.s_dat_r = 32'hA000_0000 + 32'(b);
      #1;
      check("burst_ack", bus.m_ack, 4'b0010);
      check("burst_dat_r", bus.m_dat_r, 32'hA000_0000 + 32'(b));
      ack1 += int'(bus.m_ack[1]);
      ack0 += int'(bus.m_ack[0]);
      next_cycle();
    end
    check("burst_ack1_count", 64'(ack1), 64'd8);
    check("burst_ack0_count", 64'(ack0), 64'd0);
    check("burst_still_m1", bus.gnt, 4'b0010);
    bus.s_ack    = 1'b0;
    bus.m_cyc[1] = 1'b0;
    bus.m_stb[1] = 1'b0;
    #1;
    check("burst_drop_scyc", bus.s_cyc, 1'b0);
    next_cycle(); #1;
    check("burst_gap_gnt", bus.gnt, 4'b0000);
    next_cycle(); #1;
    check("burst_m0_gnt", bus.gnt, 4'b0001);
    bus.m_cyc = '0;
    next_cycle(); #1;

    // Routing: m2 and m3 request together after m0, so m2 wins; m3's fields must not leak
    bus.m_cyc           = 4'b1100;
    bus.m_stb           = 4'b1100;
    bus.m_we            = 4'b0100;
    bus.m_adr[64 +: 32]   = 32'h1000_0040;
    bus.m_dat_w[64 +: 32] = 32'hDEAD_BEEF;
    bus.m_sel[8 +: 4]     = 4'hF;
    bus.m_cti[6 +: 3]     = 3'b000;
    bus.m_bte[4 +: 2]     = 2'b00;
    bus.m_adr[96 +: 32]   = 32'hFFFF_0000;
    bus.m_dat_w[96 +: 32] = 32'h1234_5678;
    bus.m_sel[12 +: 4]    = 4'h3;
    bus.m_cti[9 +: 3]     = 3'b111;
    bus.m_bte[6 +: 2]     = 2'b11;
    #1;
    check("idle_scyc", bus.s_cyc, 1'b0);
    check("idle_sstb", bus.s_stb, 1'b0);
    next_cycle(); #1;
    check("route_gnt", bus.gnt, 4'b0100);
    check("route_gnt_id", bus.gnt_id, 2'd2);
    check("route_adr", bus.s_adr, 32'h1000_0040);
    check("route_dat_w", bus.s_dat_w, 32'hDEAD_BEEF);
    check("route_sel", bus.s_sel, 4'hF);
    check("route_we", bus.s_we, 1'b1);
    check("route_cti", bus.s_cti, 3'b000);
    check("route_bte", bus.s_bte, 2'b00);
    bus.s_err = 1'b1;
    #1;
    check("route_err", bus.m_err, 4'b0100);
    check("route_err_noack", bus.m_ack, 4'b0000);
    bus.s_ack = 1'b1;
    #1;
    check("both_ack", bus.m_ack, 4'b0100);
    check("both_err", bus.m_err, 4'b0100);
    next_cycle();
    bus.s_ack    = 1'b0;
    bus.s_err    = 1'b0;
    bus.m_cyc[2] = 1'b0;
    bus.m_stb[2] = 1'b0;
    next_cycle();
    next_cycle(); #1;
    check("m3_gnt", bus.gnt, 4'b1000);

    // Mid-cycle reset while m3 owns the bus
    rst       = 1'b1;
    bus.m_cyc = 4'b1010;
    #1;
    check("pre_rst_scyc", bus.s_cyc, 1'b1);
    next_cycle(); #1;
    check("midrst_scyc", bus.s_cyc, 1'b0);
    check("midrst_gnt", bus.gnt, 4'b0000);
    check("midrst_gnt_id", bus.gnt_id, 2'd0);
    rst       = 1'b0;
    bus.m_cyc = 4'b0010;
    bus.m_stb = 4'b0000;
    next_cycle(); #1;
    check("postrst_gnt", bus.gnt, 4'b0010);
    check("postrst_gnt_id", bus.gnt_id, 2'd1);

    // Stalled target: m1 strobes and nothing ever answers
    bus.m_stb[1] = 1'b1;
    bus.s_ack    = 1'b0;
    bus.s_err    = 1'b0;
    #1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      check("stall_scyc", bus.s_cyc, 1'b1);
      if (i == 15) check("stall_no_err", bus.m_err, 4'b0000);
      next_cycle(); #1;
    end
    check("abort_err", bus.m_err, 4'b0010);
    check("abort_scyc", bus.s_cyc, 1'b0);
    check("abort_sstb", bus.s_stb, 1'b0);
    check("abort_gnt", bus.gnt, 4'b0010);
    next_cycle(); #1;
    check("abort_err_once", bus.m_err, 4'b0000);
    check("abort_hold_gnt", bus.gnt, 4'b0010);
`else
    repeat (1000) next_cycle();
    #1;
    check("hang_gnt", bus.gnt, 4'b0010);
    check("hang_scyc", bus.s_cyc, 1'b1);
    check("hang_sstb", bus.s_stb, 1'b1);
`endif
    bus.m_cyc = '0;
    bus.m_stb = '0;
    next_cycle();
    next_cycle(); #1;
    check("final_gnt", bus.gnt, 4'b0000);
    check("final_scyc", bus.s_cyc, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
